audio_sample_feeder: RTL and testbench
======================================

// Module: audio_sample_feeder
// PURPOSE
//  Buffers stereo PCM words arriving on a valid/accept stream and releases one
//  word per sample period. Presents held signed 16-bit left/right samples that
//  drive two sigma_dac instances directly. Sits between the bus/DMA side and
//  the DAC output stage. Generates the sample-rate tick from a runtime divider.
// PARAMETERS
//  FIFO_AW        4   log2 FIFO depth (16 stereo words)
//  UNDERRUN_ZERO  1   1: output 0x0000 (DAC midscale) on underrun; 0: hold last
// PORTS
//  clk_i            in   1         system clock
//  rst_i            in   1         synchronous reset, active-high
//  enable_i         in   1         1 = run sample-rate counter
//  flush_i          in   1         synchronous FIFO clear
//  clk_div_i        in   16        clocks per sample period (0 and 1 = every clk)
//  inport_valid_i   in   1         stereo word valid
//  inport_data_i    in   32        [31:16] left, [15:0] right; signed 2's complement
//  inport_accept_o  out  1         word accepted when valid & accept
//  left_o           out  16        held signed left sample to DAC
//  right_o          out  16        held signed right sample to DAC
//  sample_tick_o    out  1         1-clk pulse; left_o/right_o changed this cycle
//  underrun_o       out  1         1-clk pulse: tick found FIFO empty
//  level_o          out  FIFO_AW+1 current FIFO occupancy
// BEHAVIOUR
//  - Clocking: one clock domain (clk_i); reset synchronous, active-high.
//  - Reset: FIFO pointers/level = 0, div counter = 0, left_o = right_o = 0,
//    sample_tick_o = underrun_o = 0, inport_accept_o = 1 in the first
//    cycle after reset.
//  - Flush: the FIFO has no fall-through. inport_accept_o = !full.
//    flush_i empties the FIFO at the next edge and wins over any push or pop
//    that cycle. Output samples are not changed by flush_i.
//  - Divider: while enable_i = 1, the counter runs 0..N-1 and raises an
//    internal tick when count == N-1, where N = max(clk_div_i, 1).
//    The counter then wraps to 0.
//  - Disable: enable_i = 0 forces count = 0 and produces no ticks. Outputs
//    hold their values; pushes are still accepted.
//  - Divider change: a change of clk_div_i takes effect at the next compare.
//    If count >= new N-1, tick on the next cycle and wrap.
//  - Tick with data: on the internal tick with FIFO not empty, pop the head.
//    Register the head into left_o/right_o and assert sample_tick_o.
//    The new samples and the pulse both appear one clock after the tick
//    cycle: 1-clk latency, no combinational path to the DAC.
//  - Tick on empty FIFO: assert sample_tick_o and underrun_o.
//    left_o/right_o become 0 if UNDERRUN_ZERO = 1, otherwise they hold.
//  - Push and pop together (not full, not empty): both happen and
//    level_o is unchanged.
//  - Push on an empty FIFO in the same cycle as a tick: this counts as an
//    underrun. The pushed word is stored and popped on the next tick.
//  - Full FIFO: accept is low, so there is no push. A pop that cycle frees
//    a slot, and accept rises the following cycle.
//  - Pointers wrap modulo 2^FIFO_AW. Full/empty are decided by the
//    (FIFO_AW+1)-bit level.
//  - Data is passed through bit-exact. There is no scaling or sign handling;
//    the signed-to-offset conversion is done in the DAC.
// STRUCTURE
//  - Shared audio package/header holds: AUDIO_SAMPLE_W = 16, the stereo word
//    layout (LEFT_MSB = 31, LEFT_LSB = 16, RIGHT_MSB = 15, RIGHT_LSB = 0) and
//    the UNDERRUN_ZERO default.
//  - Sub-module audio_fifo: synchronous, parameterised width/depth, with push,
//    pop, flush, full, empty and level. The top level holds the divider,
//    the output registers and the underrun logic.
// TESTING
//  1 Reset, then push 0x7FFF8000 with clk_div_i = 4 and enable_i = 1.
//    -> Ticks every 4 clks. First tick gives left_o = 0x7FFF, right_o = 0x8000,
//    sample_tick_o pulse, underrun_o = 0.
//  2 Push 16 words with no ticks (enable_i = 0).
//    -> level_o = 16, accept = 0, 17th word stalls. Then enable with
//    clk_div_i = 1 -> 16 consecutive pops in order, then underrun_o every clk.
//  3 UNDERRUN_ZERO = 1, FIFO empty, last sample 0x1234/0xABCD, tick.
//    -> outputs 0x0000/0x0000 with underrun_o = 1. With UNDERRUN_ZERO = 0,
//    outputs hold 0x1234/0xABCD.
//  4 Push in the same cycle as a tick on an empty FIFO.
//    -> underrun_o = 1, level_o = 1; the next tick outputs that word.
//  5 FIFO at level 5, assert flush_i together with a push.
//    -> level_o = 0 next cycle, outputs unchanged, next tick underruns.
//  6 Assert rst_i mid-stream (level 7, count 2).
//    -> all outputs/level return to reset values next cycle, no tick for the
//    following N-1 clks.

Source files
------------

// File: rtl/audio_sample_feeder_pkg.sv
// rtl/audio_sample_feeder_pkg.sv - shared audio constants and stereo word layout
package audio_sample_feeder_pkg;

  localparam int AUDIO_SAMPLE_W = 16;
  localparam int STEREO_W       = 2 * AUDIO_SAMPLE_W;

  localparam int LEFT_MSB  = 31;
  localparam int LEFT_LSB  = 16;
  localparam int RIGHT_MSB = 15;
  localparam int RIGHT_LSB = 0;

  localparam int FIFO_AW_DEFAULT       = 4;
  localparam bit UNDERRUN_ZERO_DEFAULT = 1'b1;

  // Field order matches LEFT_*/RIGHT_* so a packed cast splits the word.
  typedef struct packed {
    logic [AUDIO_SAMPLE_W-1:0] left;
    logic [AUDIO_SAMPLE_W-1:0] right;
  } stereo_t;

  function automatic stereo_t unpack_stereo(input logic [STEREO_W-1:0] word);
    stereo_t s;
    s.left  = word[LEFT_MSB:LEFT_LSB];
    s.right = word[RIGHT_MSB:RIGHT_LSB];
    return s;
  endfunction

endpackage

// File: rtl/audio_fifo.sv
// rtl/audio_fifo.sv - synchronous FIFO with flush, full/empty decided by level
module audio_fifo #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - paces buffered stereo PCM words out at a divided sample rate
module audio_sample_feeder
  import audio_sample_feeder_pkg::*;
#(
  parameter int FIFO_AW       = FIFO_AW_DEFAULT,
  parameter bit UNDERRUN_ZERO = UNDERRUN_ZERO_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      flush_i,
  input  logic [15:0]               clk_div_i,
  input  logic                      inport_valid_i,
  input  logic [STEREO_W-1:0]       inport_data_i,
  output logic                      inport_accept_o,
  output logic [AUDIO_SAMPLE_W-1:0] left_o,
  output logic [AUDIO_SAMPLE_W-1:0] right_o,
  output logic                      sample_tick_o,
  output logic                      underrun_o,
  output logic [FIFO_AW:0]          level_o
);

  logic [15:0]         div_count;
  logic [15:0]         div_last;
  logic                tick;
  logic                fifo_full;
  logic                fifo_empty;
  logic [STEREO_W-1:0] fifo_rdata;
  logic                have_data;
  stereo_t             head;

  // Compare with >= so a divider shrunk below the running count wraps at once.
  assign div_last = (clk_div_i == 16'd0) ? 16'd0 : clk_div_i - 16'd1;
  assign tick     = enable_i && (div_count >= div_last);

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i || tick) div_count <= 16'd0;
    else                            div_count <= div_count + 16'd1;
  end

  audio_fifo #(
    .W  (STEREO_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (inport_valid_i),
    .wdata (inport_data_i),
    .pop   (tick),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign inport_accept_o = !fifo_full;
  assign head            = unpack_stereo(fifo_rdata);
  assign have_data       = !fifo_empty && !flush_i;

  // A tick that coincides with flush delivers nothing and leaves the outputs as they are.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      left_o        <= '0;
      right_o       <= '0;
      sample_tick_o <= 1'b0;
      underrun_o    <= 1'b0;
    end else if (tick) begin
      sample_tick_o <= 1'b1;
      if (have_data) begin
        left_o     <= head.left;
        right_o    <= head.right;
        underrun_o <= 1'b0;
      end else begin
        underrun_o <= 1'b1;
        if (UNDERRUN_ZERO && !flush_i) begin
          left_o  <= '0;
          right_o <= '0;
        end
      end
    end else begin
      sample_tick_o <= 1'b0;
      underrun_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb/tb_audio_sample_feeder.sv - queue-model checked bench for audio_sample_feeder
module tb_audio_sample_feeder;

  logic        clk = 1'b0;
  logic        rst, en, flush, valid;
  logic [15:0] div;
  logic [31:0] data;

  logic        accept_z, tick_z, under_z, accept_h, tick_h, under_h;
  logic [15:0] left_z, right_z, left_h, right_h;
  logic [4:0]  level_z, level_h;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q[$];
  int          cnt;
  logic [15:0] e_left_z, e_right_z, e_left_h, e_right_h;
  logic        e_tick, e_under;

  always #5 clk = ~clk;

  audio_sample_feeder #(.FIFO_AW(4), .UNDERRUN_ZERO(1'b1)) dut_z (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .flush_i(flush), .clk_div_i(div),
    .inport_valid_i(valid), .inport_data_i(data), .inport_accept_o(accept_z),
    .left_o(left_z), .right_o(right_z), .sample_tick_o(tick_z),
    .underrun_o(under_z), .level_o(level_z)
  );

  audio_sample_feeder #(.FIFO_AW(4), .UNDERRUN_ZERO(1'b0)) dut_h (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .flush_i(flush), .clk_div_i(div),
    .inport_valid_i(valid), .inport_data_i(data), .inport_accept_o(accept_h),
    .left_o(left_h), .right_o(right_h), .sample_tick_o(tick_h),
    .underrun_o(under_h), .level_o(level_h)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference behaviour, computed from the current inputs.
  task automatic model_edge();
    int   n;
    bit   tk, room;
    logic [31:0] w;
    n    = (div == 16'd0) ? 1 : int'(div);
    tk   = en && (cnt >= n - 1);
    room = q.size() < 16;
    if (rst) begin
      q.delete();
      cnt = 0;
      {e_left_z, e_right_z, e_left_h, e_right_h} = '0;
      e_tick = 1'b0;
      e_under = 1'b0;
      return;
    end
    e_tick  = tk;
    e_under = 1'b0;
    if (flush) begin
      q.delete();
      if (tk) e_under = 1'b1;
    end else begin
      if (tk) begin
        if (q.size() > 0) begin
          w = q.pop_front();
          e_left_z = w[31:16]; e_right_z = w[15:0];
          e_left_h = w[31:16]; e_right_h = w[15:0];
        end else begin
          e_under = 1'b1;
          e_left_z = '0; e_right_z = '0;
        end
      end
      if (valid && room) q.push_back(data);
    end
    cnt = (!en || tk) ? 0 : cnt + 1;
  endtask

  task automatic compare_all();
    chk("left_z",   32'(left_z),   32'(e_left_z));
    chk("right_z",  32'(right_z),  32'(e_right_z));
    chk("left_h",   32'(left_h),   32'(e_left_h));
    chk("right_h",  32'(right_h),  32'(e_right_h));
    chk("tick_z",   32'(tick_z),   32'(e_tick));
    chk("tick_h",   32'(tick_h),   32'(e_tick));
    chk("under_z",  32'(under_z),  32'(e_under));
    chk("under_h",  32'(under_h),  32'(e_under));
    chk("level_z",  32'(level_z),  q.size());
    chk("level_h",  32'(level_h),  q.size());
    chk("accept_z", 32'(accept_z), 32'(q.size() < 16));
    chk("accept_h", 32'(accept_h), 32'(q.size() < 16));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run_to_tick(input int limit, output int taken);
    taken = 0;
    do begin
      step();
      taken++;
    end while (!tick_z && taken < limit);
    if (!tick_z) chk("tick_timeout", 0, 1);
  endtask

  initial begin
    int          k;
    logic [31:0] w;
    logic [15:0] held_l, held_r;
    int          div_tbl[6] = '{0, 1, 2, 3, 5, 7};

    rst = 1'b1; en = 1'b0; flush = 1'b0; valid = 1'b0; div = 16'd4; data = '0;
    step(); step();
    chk("rst_accept", 32'(accept_z), 1);
    chk("rst_level", 32'(level_z), 0);
    rst = 1'b0;

    // First tick delivers the pushed word, then ticks every 4 clocks.
    valid = 1'b1; data = 32'h7FFF8000; step(); valid = 1'b0;
    en = 1'b1;
    run_to_tick(8, k);
    chk("t1_left", 32'(left_z), 32'h7FFF);
    chk("t1_right", 32'(right_z), 32'h8000);
    chk("t1_under", 32'(under_z), 0);
    run_to_tick(10, k);
    chk("t1_period", k, 4);

    // Fill to full with the divider stopped, 17th word stalls.
    en = 1'b0; valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data = $urandom; step();
    end
    valid = 1'b0;
    chk("t2_level", 32'(level_z), 16);
    chk("t2_accept", 32'(accept_z), 0);
    en = 1'b1; div = 16'd1;
    for (int i = 0; i < 16; i++) step();
    chk("t2_drained", 32'(level_z), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_underrun", 32'(under_z), 1);
    end

    // Underrun zeroes or holds depending on UNDERRUN_ZERO.
    en = 1'b0; valid = 1'b1; data = 32'h1234ABCD; step(); valid = 1'b0;
    en = 1'b1; div = 16'd2;
    run_to_tick(6, k);
    chk("t3_left", 32'(left_h), 32'h1234);
    run_to_tick(6, k);
    chk("t3_zero_l", 32'(left_z), 0);
    chk("t3_zero_r", 32'(right_z), 0);
    chk("t3_hold_l", 32'(left_h), 32'h1234);
    chk("t3_hold_r", 32'(right_h), 32'hABCD);
    chk("t3_under", 32'(under_h), 1);

    // Push lands in the same cycle as a tick on an empty FIFO.
    div = 16'd3;
    k = 0;
    while (cnt < 2 && k < 10) begin step(); k++; end
    w = $urandom; valid = 1'b1; data = w; step(); valid = 1'b0;
    chk("t4_under", 32'(under_z), 1);
    chk("t4_level", 32'(level_z), 1);
    run_to_tick(6, k);
    chk("t4_left", 32'(left_z), 32'(w[31:16]));
    chk("t4_right", 32'(right_z), 32'(w[15:0]));

    // Flush beats a simultaneous push and leaves the outputs alone.
    en = 1'b0; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin data = $urandom; step(); end
    chk("t5_level", 32'(level_z), 5);
    held_l = left_z; held_r = right_z;
    flush = 1'b1; data = $urandom; step(); flush = 1'b0; valid = 1'b0;
    chk("t5_flushed", 32'(level_z), 0);
    chk("t5_hold_l", 32'(left_z), 32'(held_l));
    chk("t5_hold_r", 32'(right_z), 32'(held_r));
    en = 1'b1; div = 16'd2;
    run_to_tick(6, k);
    chk("t5_under", 32'(under_z), 1);

    // Reset mid-stream at level 7, count 2.
    en = 1'b0; valid = 1'b1;
    for (int i = 0; i < 7; i++) begin data = $urandom; step(); end
    valid = 1'b0; en = 1'b1; div = 16'd4;
    step(); step();
    chk("t6_count", cnt, 2);
    chk("t6_level", 32'(level_z), 7);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst_level", 32'(level_z), 0);
    chk("t6_rst_left", 32'(left_z), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_tick", 32'(tick_z), 0);
    end
    step();
    chk("t6_tick", 32'(tick_z), 1);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) div = 16'(div_tbl[$urandom_range(5)]);
      en    = ($urandom_range(9) != 0);
      valid = ($urandom_range(2) != 0);
      data  = $urandom;
      flush = ($urandom_range(96) == 0);
      rst   = ($urandom_range(700) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
